// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: requests a word at pc, holds it
// for the consumer, then advances pc sequentially or along a branch/jump.
module pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count,
    output logic        misalign_err
);

    typedef enum logic {FETCH, VALID} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] next_pc;
    logic        advance;
    logic        jr_misaligned;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign advance   = (state == VALID) && !stall;

    // Target selection only matters on an advance; redirect=0 always falls through.
    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        if (redirect) begin
            case (pc_src)
                2'b01:   next_pc = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
                2'b10:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
                2'b11: begin
                    next_pc       = {jr_target[31:2], 2'b00};
                    jr_misaligned = (jr_target[1:0] != 2'b00);
                end
                default: next_pc = pc_plus4;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (!stall) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset wins over everything, including an ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_VECTOR;
            instr        <= 32'd0;
            instr_count  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (advance) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
                if (jr_misaligned) misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: walks reset, stall, sequential, branch, jump
// and jump-register advances with hand-computed pc values.
module tb_pc_fetch;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [1:0]  pc_src;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    pc_fetch #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .pc_src(pc_src), .branch_imm(branch_imm), .jump_index(jump_index),
        .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .instr_count(instr_count),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic fetchWord(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] src, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] jr);
        stall      = 1'b0;
        redirect   = r;
        pc_src     = src;
        branch_imm = imm;
        jump_index = idx;
        jr_target  = jr;
        step();
        redirect   = 1'b0;
        pc_src     = 2'b00;
    endtask

    task automatic fetchAndAdvance(input logic r, input logic [1:0] src, input logic [15:0] imm,
                                   input logic [25:0] idx, input logic [31:0] jr);
        fetchWord(32'h0000_0013);
        applyStimulus(r, src, imm, idx, jr);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; pc_src = 2'b00;
        branch_imm = 16'd0; jump_index = 26'd0; jr_target = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        step();
        step();
        reset = 1'b0;
        checkOutput("reset_pc", pc, RV);
        checkOutput("reset_addr", imem_addr, RV);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd1);
        checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_count", instr_count, 32'd0);
        checkOutput("reset_misalign", {31'd0, misalign_err}, 32'd0);

        fetchWord(32'h2008_0005);
        checkOutput("first_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("first_instr", instr, 32'h2008_0005);
        checkOutput("first_pc", pc, RV);
        checkOutput("first_req", {31'd0, imem_req}, 32'd0);

        // Stalled in VALID: a stray ack and redirect must both be ignored.
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1; pc_src = 2'b10; jump_index = 26'h3FF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_pc", pc, RV);
            checkOutput("stall_instr", instr, 32'h2008_0005);
            checkOutput("stall_count", instr_count, 32'd0);
            checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;
        applyStimulus(1'b0, 2'b10, 16'd0, 26'h3FF_FFFF, 32'd0);
        checkOutput("seq_pc", pc, 32'h0040_0004);
        checkOutput("seq_count", instr_count, 32'd1);
        checkOutput("seq_req", {31'd0, imem_req}, 32'd1);
        checkOutput("seq_valid", {31'd0, instr_valid}, 32'd0);

        step();
        step();
        checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
        checkOutput("wait_addr", imem_addr, 32'h0040_0004);
        checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("wait_instr", instr, 32'h2008_0005);

        for (int i = 0; i < 3; i++) fetchAndAdvance(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        checkOutput("walk_pc", pc, 32'h0040_0010);
        fetchAndAdvance(1'b1, 2'b01, 16'hFFFC, 26'd0, 32'd0);
        checkOutput("branch_back_pc", pc, 32'h0040_0004);
        checkOutput("branch_back_count", instr_count, 32'd5);

        for (int i = 0; i < 3; i++) fetchAndAdvance(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        fetchAndAdvance(1'b1, 2'b01, 16'h0003, 26'd0, 32'd0);
        checkOutput("branch_fwd_pc", pc, 32'h0040_0020);
        checkOutput("branch_fwd_count", instr_count, 32'd9);

        fetchAndAdvance(1'b1, 2'b10, 16'd0, 26'h3FF_FFFF, 32'd0);
        checkOutput("jump_pc", pc, 32'h0FFF_FFFC);
        fetchAndAdvance(1'b1, 2'b10, 16'd0, 26'h000_0001, 32'd0);
        checkOutput("jump_region_pc", pc, 32'h1000_0004);
        checkOutput("jump_region_misalign", {31'd0, misalign_err}, 32'd0);

        fetchAndAdvance(1'b1, 2'b11, 16'd0, 26'd0, 32'h0040_0102);
        checkOutput("jr_pc", pc, 32'h0040_0100);
        checkOutput("jr_misalign", {31'd0, misalign_err}, 32'd1);
        checkOutput("jr_count", instr_count, 32'd12);
        fetchAndAdvance(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        checkOutput("sticky_pc", pc, 32'h0040_0104);
        checkOutput("sticky_misalign", {31'd0, misalign_err}, 32'd1);

        fetchAndAdvance(1'b1, 2'b11, 16'd0, 26'd0, 32'hFFFF_FFFC);
        checkOutput("top_pc", pc, 32'hFFFF_FFFC);
        checkOutput("top_pc_plus4", pc_plus4, 32'd0);
        fetchAndAdvance(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        checkOutput("wrap_pc", pc, 32'd0);
        fetchAndAdvance(1'b1, 2'b00, 16'h0003, 26'd5, 32'd0);
        checkOutput("src00_pc", pc, 32'd4);
        checkOutput("src00_count", instr_count, 32'd16);

        // Reset coincident with an ack must not capture the word.
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; reset = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        checkOutput("rst_ack_instr", instr, 32'd0);
        checkOutput("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_ack_addr", imem_addr, RV);
        checkOutput("rst_ack_req", {31'd0, imem_req}, 32'd1);
        checkOutput("rst_ack_count", instr_count, 32'd0);
        checkOutput("rst_ack_misalign", {31'd0, misalign_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0040_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  consumer not ready; holds the current instruction.
REQ-005 redirect  input  1  current instruction changes control flow; use pc_src.
REQ-006 pc_src  input  2  00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-007 branch_imm  input  16  signed branch offset in words.
REQ-008 jump_index  input  26  J-type instruction index field.
REQ-009 jr_target  input  32  register-sourced jump target.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  fetch address, equal to pc.
REQ-012 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 instr_valid  output  1  instr holds a fetched instruction for the consumer.
REQ-015 instr  output  32  captured instruction word.
REQ-016 pc  output  32  address of the current instruction.
REQ-017 pc_plus4  output  32  pc + 4, combinational.
REQ-018 instr_count  output  32  count of instructions advanced past.
REQ-019 misalign_err  output  1  sticky flag: a misaligned jr_target was seen.

Function
REQ-020 The block SHALL use a two-state FSM, FETCH and VALID.
- FETCH: imem_req=1 and instr_valid=0.
- VALID: imem_req=0 and instr_valid=1.
REQ-021 In FETCH, imem_ack sampled high at a clock edge SHALL load instr from imem_rdata and move the FSM to VALID.
- Minimum latency: ack in cycle N gives instr_valid in cycle N+1.
REQ-022 In FETCH without imem_ack, the block SHALL hold all state and keep imem_req asserted with a stable imem_addr.
REQ-023 imem_ack SHALL be ignored in VALID.
REQ-024 In VALID with stall=1, the block SHALL hold pc, instr, instr_count and state unchanged.
REQ-025 In VALID with stall=0, the block SHALL perform all of the following at that edge:
- load pc with next_pc;
- increment instr_count by 1, wrapping 2^32-1 -> 0;
- return the FSM to FETCH.
REQ-026 When redirect=0, next_pc SHALL be pc_plus4 regardless of pc_src.
REQ-027 When redirect=1, next_pc SHALL be selected by pc_src:
- 01: pc_plus4 + {sign-extended branch_imm, 2'b00}, modulo 2^32.
- 10: {pc_plus4[31:28], jump_index, 2'b00}.
- 11: {jr_target[31:2], 2'b00}.
- 00: pc_plus4.
REQ-028 pc_plus4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 The jump region SHALL be taken from pc_plus4[31:28], not pc[31:28].
- Example: pc=32'h0FFF_FFFC uses region 4'h1.
REQ-030 A jump-register advance with jr_target[1:0] != 0 SHALL set misalign_err, which stays set until reset.
REQ-031 redirect, pc_src, branch_imm, jump_index and jr_target SHALL be ignored except in VALID with stall=0.
REQ-032 imem_addr SHALL always equal pc; pc[1:0] SHALL always be 2'b00.

Reset
REQ-033 When reset=1 at an edge, the block SHALL take these values, overriding all other inputs:
- pc=RESET_VECTOR and state=FETCH;
- instr=0 and instr_valid=0;
- instr_count=0 and misalign_err=0.
REQ-034 A reset during an outstanding fetch SHALL abandon it; the ack cycle coincident with reset SHALL NOT load instr.
REQ-035 In the first cycle after reset, the block SHALL drive imem_req=1 and imem_addr=RESET_VECTOR.

Verification
REQ-036 Reset, then ack with rdata=32'h2008_0005 in the first cycle -> next cycle instr_valid=1, instr=32'h2008_0005, pc=32'h0040_0000.
REQ-037 In VALID, stall=1 for 3 cycles, then stall=0 with redirect=0 -> pc/instr/instr_count held for 3 cycles, then pc=32'h0040_0004, instr_count=1, imem_req=1.
REQ-038 pc=32'h0040_0010, redirect=1, pc_src=01, branch_imm=16'hFFFC -> pc=32'h0040_0004; branch_imm=16'h0003 -> pc=32'h0040_0020.
REQ-039 pc=32'h0FFF_FFFC, pc_src=10, jump_index=26'h000_0001 -> pc=32'h1000_0004.
REQ-040 pc_src=11, jr_target=32'h0040_0102 -> pc=32'h0040_0100, misalign_err=1, and misalign_err stays 1 until reset.
REQ-041 Assert reset while in FETCH with ack high -> instr=0, instr_valid=0, and imem_addr=RESET_VECTOR on the following cycle.
